// File: rtl/pcu_multistage_pkg.sv
// Shared types for the multistage pipeline control unit: opcode classes,
// FSM states and the per-stage shadow record.
package pcu_multistage_pkg;

   typedef enum logic [3:0] {
      OP_NO_OP,
      OP_COMP,
      OP_COMP_IMM,
      OP_LOAD,
      OP_STORE,
      OP_BRANCH,
      OP_JAL,
      OP_JALR,
      OP_LUI,
      OP_AUIPC
   } decoded_opcode;

   typedef enum logic [1:0] {
      S_RESET,
      S_WORK,
      S_FLUSH,
      S_LOAD_WAIT
   } pcu_state_e;

   // Shadow records carry a fixed-width rd; ADDR_WIDTH may not exceed this.
   localparam int unsigned PCU_MAX_ADDR_W = 8;

   typedef struct packed {
      decoded_opcode               instr_type;
      logic [PCU_MAX_ADDR_W-1:0]   write_addr;
      logic                        write_en;
   } pcu_stage_t;

   localparam pcu_stage_t PCU_STAGE_EMPTY = '{instr_type: OP_NO_OP, write_addr: '0, write_en: 1'b0};

   function automatic logic uses_rs1(input decoded_opcode op);
      return (op == OP_COMP) || (op == OP_STORE) || (op == OP_BRANCH) ||
             (op == OP_COMP_IMM) || (op == OP_LOAD) || (op == OP_JALR);
   endfunction

   function automatic logic uses_rs2(input decoded_opcode op);
      return (op == OP_COMP) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/pcu_multistage_fwd_select.sv
// Forwarding source picker for one operand: youngest downstream stage
// that writes the requested register wins; x0 never forwards.
module pcu_fwd_select
   import pcu_multistage_pkg::*;
#(
   parameter int unsigned NUM_FWD_STAGES = 2,
   parameter int unsigned ADDR_WIDTH     = 5
) (
   input  logic [ADDR_WIDTH-1:0]                 rs,
   input  logic                                  use_rs,
   input  pcu_stage_t                            stages [NUM_FWD_STAGES],
   output logic [$clog2(NUM_FWD_STAGES+1)-1:0]   sel
);

   localparam int unsigned SEL_W = $clog2(NUM_FWD_STAGES + 1);

   logic [PCU_MAX_ADDR_W-1:0] rs_ext;
   logic                      hit;

   assign rs_ext = PCU_MAX_ADDR_W'(rs);

   always_comb begin
      sel = '0;
      hit = 1'b0;
      if (use_rs && (rs != '0)) begin
         for (int unsigned k = 0; k < NUM_FWD_STAGES; k++) begin
            if (!hit && stages[k].write_en && (stages[k].write_addr == rs_ext)) begin
               sel = SEL_W'(k + 1);
               hit = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pcu_multistage.sv
// Pipeline control unit: tracks NUM_FWD_STAGES downstream shadow stages and
// drives stall/clear/forward controls, flushes and the LSU load-wait timeout.
module pcu_multistage
   import pcu_multistage_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH         = 5,
   parameter int unsigned NUM_FWD_STAGES     = 2,
   parameter int unsigned BRANCH_FLUSH_DEPTH = 2,
   parameter int unsigned JUMP_FLUSH_DEPTH   = 1,
   parameter int unsigned LOAD_TIMEOUT       = 15
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  decoded_opcode                         instr_type_i,
   input  logic [ADDR_WIDTH-1:0]                 read_addr1_i,
   input  logic [ADDR_WIDTH-1:0]                 read_addr2_i,
   input  logic [ADDR_WIDTH-1:0]                 write_addr_i,
   input  logic                                  write_en_i,
   input  logic                                  valid_lsu_load_i,
   input  logic                                  branch_taken_i,
   input  logic                                  jump_taken_i,
   output logic [NUM_FWD_STAGES+1:0]             stall_o,
   output logic [NUM_FWD_STAGES+1:0]             clear_o,
   output logic [$clog2(NUM_FWD_STAGES+1)-1:0]   fwrd_opA_sel_o,
   output logic [$clog2(NUM_FWD_STAGES+1)-1:0]   fwrd_opB_sel_o,
   output logic                                  load_timeout_o
);

   localparam int unsigned N         = NUM_FWD_STAGES;
   localparam int unsigned SEL_W     = $clog2(N + 1);
   localparam int unsigned FLUSH_MAX = (BRANCH_FLUSH_DEPTH > JUMP_FLUSH_DEPTH) ?
                                       BRANCH_FLUSH_DEPTH : JUMP_FLUSH_DEPTH;
   localparam int unsigned FLUSH_W   = (FLUSH_MAX > 1) ? $clog2(FLUSH_MAX) : 1;
   localparam int unsigned WAIT_W    = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;

   localparam logic [FLUSH_W-1:0] BR_RELOAD  = FLUSH_W'(BRANCH_FLUSH_DEPTH - 1);
   localparam logic [FLUSH_W-1:0] JMP_RELOAD = FLUSH_W'(JUMP_FLUSH_DEPTH - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(LOAD_TIMEOUT);

   pcu_state_e          state_q, state_d;
   logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                flush_first;
   logic                timeout;

   pcu_stage_t          id_stage;
   pcu_stage_t          stage_q   [N];
   pcu_stage_t          stage_src [N];

   logic                use1, use2, load_use;
   logic [SEL_W-1:0]    sel_a_raw, sel_b_raw;

   assign id_stage = '{instr_type: instr_type_i,
                       write_addr: PCU_MAX_ADDR_W'(write_addr_i),
                       write_en:   write_en_i};

   assign use1 = uses_rs1(instr_type_i);
   assign use2 = uses_rs2(instr_type_i);

   assign load_use = stage_q[0].write_en && (stage_q[0].instr_type == OP_LOAD) &&
                     ((use1 && (read_addr1_i != '0) &&
                       (stage_q[0].write_addr == PCU_MAX_ADDR_W'(read_addr1_i))) ||
                      (use2 && (read_addr2_i != '0) &&
                       (stage_q[0].write_addr == PCU_MAX_ADDR_W'(read_addr2_i))));

   pcu_fwd_select #(
      .NUM_FWD_STAGES (N),
      .ADDR_WIDTH     (ADDR_WIDTH)
   ) u_fwd_a (
      .rs     (read_addr1_i),
      .use_rs (use1),
      .stages (stage_q),
      .sel    (sel_a_raw)
   );

   pcu_fwd_select #(
      .NUM_FWD_STAGES (N),
      .ADDR_WIDTH     (ADDR_WIDTH)
   ) u_fwd_b (
      .rs     (read_addr2_i),
      .use_rs (use2),
      .stages (stage_q),
      .sel    (sel_b_raw)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_RESET;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      flush_first = 1'b0;
      timeout     = 1'b0;
      if (!rst_n) begin
         state_d     = S_RESET;
         flush_cnt_d = '0;
         wait_cnt_d  = '0;
      end else begin
         case (state_q)
            S_RESET: state_d = S_WORK;
            S_WORK: begin
               if ((stage_q[N-1].instr_type == OP_LOAD) && !valid_lsu_load_i) begin
                  state_d    = S_LOAD_WAIT;
                  wait_cnt_d = '0;
               end else if (branch_taken_i) begin
                  state_d     = S_FLUSH;
                  flush_cnt_d = BR_RELOAD;
                  flush_first = 1'b1;
               end else if (jump_taken_i) begin
                  state_d     = S_FLUSH;
                  flush_cnt_d = JMP_RELOAD;
               end
            end
            S_FLUSH: begin
               if (branch_taken_i) begin
                  flush_cnt_d = BR_RELOAD;
                  flush_first = 1'b1;
               end else if (jump_taken_i) begin
                  flush_cnt_d = JMP_RELOAD;
               end else if (flush_cnt_q == '0) begin
                  state_d = S_WORK;
               end else begin
                  flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
               end
            end
            S_LOAD_WAIT: begin
               if (valid_lsu_load_i) begin
                  wait_cnt_d = '0;
                  if (branch_taken_i) begin
                     state_d     = S_FLUSH;
                     flush_cnt_d = BR_RELOAD;
                     flush_first = 1'b1;
                  end else begin
                     state_d = S_WORK;
                  end
               end else if (wait_cnt_q == WAIT_LIMIT) begin
                  state_d    = S_WORK;
                  wait_cnt_d = '0;
                  timeout    = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
            default: state_d = S_RESET;
         endcase
      end
   end

   // Controls follow the state being entered, so a hazard acts in the same cycle.
   always_comb begin
      stall_o        = '0;
      clear_o        = '0;
      fwrd_opA_sel_o = '0;
      fwrd_opB_sel_o = '0;
      load_timeout_o = 1'b0;
      case (state_d)
         S_RESET: clear_o = {{(N + 1){1'b1}}, 1'b0};
         S_WORK: begin
            load_timeout_o = timeout;
            if (load_use) begin
               stall_o[1:0] = 2'b11;
               clear_o[2]   = 1'b1;
            end else begin
               fwrd_opA_sel_o = sel_a_raw;
               fwrd_opB_sel_o = sel_b_raw;
            end
         end
         S_FLUSH: begin
            clear_o[1]     = 1'b1;
            clear_o[2]     = flush_first;
            fwrd_opA_sel_o = sel_a_raw;
            fwrd_opB_sel_o = sel_b_raw;
         end
         S_LOAD_WAIT: stall_o = '1;
         default: ;
      endcase
   end

   always_comb begin
      stage_src[0] = id_stage;
      for (int unsigned k = 1; k < N; k++) begin
         stage_src[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < N; k++) begin
         if (!rst_n || clear_o[k+2]) begin
            stage_q[k] <= PCU_STAGE_EMPTY;
         end else if (!stall_o[k+2]) begin
            stage_q[k] <= stage_src[k];
         end
      end
   end

endmodule

// File: tb/tb_pcu_multistage.sv
// Self-checking bench for pcu_multistage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pcu_multistage;
   import pcu_multistage_pkg::*;

   localparam int unsigned N     = 2;
   localparam int unsigned AW    = 5;
   localparam int unsigned BR_D  = 3;
   localparam int unsigned JMP_D = 1;
   localparam int unsigned TMO   = 15;
   localparam int unsigned SW    = $clog2(N + 1);
   localparam int          ALL1  = (1 << (N + 2)) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   decoded_opcode   instr_type = OP_NO_OP;
   logic [AW-1:0]   ra1 = '0, ra2 = '0, wa = '0;
   logic            we = 1'b0, valid = 1'b1, br = 1'b0, jmp = 1'b0;
   logic [N+1:0]    stall, clear;
   logic [SW-1:0]   sel_a, sel_b;
   logic            tmo;

   always #5 clk = ~clk;

   pcu_multistage #(
      .ADDR_WIDTH         (AW),
      .NUM_FWD_STAGES     (N),
      .BRANCH_FLUSH_DEPTH (BR_D),
      .JUMP_FLUSH_DEPTH   (JMP_D),
      .LOAD_TIMEOUT       (TMO)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .instr_type_i     (instr_type),
      .read_addr1_i     (ra1),
      .read_addr2_i     (ra2),
      .write_addr_i     (wa),
      .write_en_i       (we),
      .valid_lsu_load_i (valid),
      .branch_taken_i   (br),
      .jump_taken_i     (jmp),
      .stall_o          (stall),
      .clear_o          (clear),
      .fwrd_opA_sel_o   (sel_a),
      .fwrd_opB_sel_o   (sel_b),
      .load_timeout_o   (tmo)
   );

   // Model: instructions in flight downstream of ID plus the control mode.
   typedef struct { decoded_opcode op; int rd; bit we; } ins_t;
   ins_t pipe [1:N];
   bit   m_reset;       // last cycle held in reset
   bit   m_flush;       // front end being flushed
   int   m_flush_owed;  // extra flush cycles still owed
   int   m_stalled;     // cycles stalled on the pending load, 0 = none

   int e_stall, e_clear, e_sel_a, e_sel_b, e_tmo;
   int n_checks = 0, n_pass = 0;

   function automatic bit reads1(decoded_opcode op);
      return op inside {OP_COMP, OP_STORE, OP_BRANCH, OP_COMP_IMM, OP_LOAD, OP_JALR};
   endfunction

   function automatic bit reads2(decoded_opcode op);
      return op inside {OP_COMP, OP_STORE, OP_BRANCH};
   endfunction

   function automatic int fwd_of(int rs, bit used);
      if (!used || rs == 0) return 0;
      for (int k = 1; k <= N; k++)
         if (pipe[k].we && pipe[k].rd == rs) return k;
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Expected outputs for the current inputs, then advance the model one cycle.
   task automatic model_step();
      int  mode;   // 0 reset, 1 run, 2 flush, 3 wait on load
      bit  first, lu, bubble;
      int  fa, fb, owed;
      first = 0; e_tmo = 0; owed = m_flush_owed;
      if (!rst_n) mode = 0;
      else if (m_reset) mode = 1;
      else if (m_stalled > 0) begin
         if (valid) begin
            if (br) begin mode = 2; first = 1; owed = BR_D - 1; end
            else mode = 1;
         end else if (m_stalled == TMO + 1) begin
            mode = 1; e_tmo = 1;
         end else mode = 3;
      end else if (m_flush) begin
         if (br) begin mode = 2; first = 1; owed = BR_D - 1; end
         else if (jmp) begin mode = 2; owed = JMP_D - 1; end
         else if (m_flush_owed == 0) mode = 1;
         else begin mode = 2; owed = m_flush_owed - 1; end
      end else begin
         if (pipe[N].op == OP_LOAD && !valid) mode = 3;
         else if (br) begin mode = 2; first = 1; owed = BR_D - 1; end
         else if (jmp) begin mode = 2; owed = JMP_D - 1; end
         else mode = 1;
      end

      lu = pipe[1].we && pipe[1].op == OP_LOAD && pipe[1].rd != 0 &&
           ((reads1(instr_type) && int'(ra1) == pipe[1].rd) ||
            (reads2(instr_type) && int'(ra2) == pipe[1].rd));
      fa = fwd_of(int'(ra1), reads1(instr_type));
      fb = fwd_of(int'(ra2), reads2(instr_type));

      e_stall = 0; e_clear = 0; e_sel_a = 0; e_sel_b = 0;
      case (mode)
         0: e_clear = ALL1 - 1;
         1: if (lu) begin e_stall = 3; e_clear = 4; end
            else begin e_sel_a = fa; e_sel_b = fb; end
         2: begin e_clear = first ? 6 : 2; e_sel_a = fa; e_sel_b = fb; end
         default: e_stall = ALL1;
      endcase

      bubble = (mode == 1 && lu) || (mode == 2 && first);
      if (mode == 0) begin
         for (int k = 1; k <= N; k++) pipe[k] = '{OP_NO_OP, 0, 1'b0};
      end else if (mode != 3) begin
         for (int k = N; k >= 2; k--) pipe[k] = pipe[k-1];
         if (bubble) pipe[1] = '{OP_NO_OP, 0, 1'b0};
         else pipe[1] = '{instr_type, int'(wa), bit'(we)};
      end
      m_reset      = (mode == 0);
      m_flush      = (mode == 2);
      m_flush_owed = (mode == 2) ? owed : 0;
      m_stalled    = (mode == 3) ? m_stalled + 1 : 0;
   endtask

   task automatic step(input bit rn, input decoded_opcode op, input int r1, input int r2,
                       input int rd, input bit w, input bit v, input bit b, input bit j);
      @(negedge clk);
      rst_n = rn; instr_type = op; ra1 = AW'(r1); ra2 = AW'(r2); wa = AW'(rd);
      we = w; valid = v; br = b; jmp = j;
      #1;
      model_step();
      check("stall", 32'(stall), 32'(e_stall));
      check("clear", 32'(clear), 32'(e_clear));
      check("fwd_a", 32'(sel_a), 32'(e_sel_a));
      check("fwd_b", 32'(sel_b), 32'(e_sel_b));
      check("timeout", 32'(tmo), 32'(e_tmo));
   endtask

   task automatic nop(input bit v);
      step(1, OP_NO_OP, 0, 0, 0, 0, v, 0, 0);
   endtask

   initial begin
      for (int k = 1; k <= N; k++) pipe[k] = '{OP_NO_OP, 0, 1'b0};
      m_reset = 1; m_flush = 0; m_flush_owed = 0; m_stalled = 0;

      for (int i = 0; i < 3; i++) step(0, OP_NO_OP, 0, 0, 0, 0, 1, 0, 0);
      check("rst_clear", 32'(clear), 32'h0000_000e);
      check("rst_stall", 32'(stall), 32'h0);
      nop(1);
      check("work_clear", 32'(clear), 32'h0);
      check("work_stall", 32'(stall), 32'h0);

      // ADD x5 ; SUB x6,x5,x5
      step(1, OP_COMP, 1, 2, 5, 1, 1, 0, 0);
      step(1, OP_COMP, 5, 5, 6, 1, 1, 0, 0);
      check("fwd1_a", 32'(sel_a), 32'd1);
      check("fwd1_b", 32'(sel_b), 32'd1);
      // ADD x5 ; unrelated ; SUB x6,x5,x5
      step(1, OP_COMP, 1, 2, 5, 1, 1, 0, 0);
      step(1, OP_COMP, 1, 2, 9, 1, 1, 0, 0);
      step(1, OP_COMP, 5, 5, 6, 1, 1, 0, 0);
      check("fwd2_a", 32'(sel_a), 32'd2);
      check("fwd2_b", 32'(sel_b), 32'd2);
      // rd = x0 never forwards
      step(1, OP_COMP, 1, 2, 0, 1, 1, 0, 0);
      step(1, OP_COMP, 0, 0, 6, 1, 1, 0, 0);
      check("fwd_x0", 32'({sel_a, sel_b}), 32'd0);
      // LW x7 ; ADDI x8,x7,1
      step(1, OP_LOAD, 1, 0, 7, 1, 1, 0, 0);
      step(1, OP_COMP_IMM, 7, 0, 8, 1, 1, 0, 0);
      check("lu_stall", 32'(stall[1:0]), 32'd3);
      check("lu_clear2", 32'(clear[2]), 32'd1);
      check("lu_fwd0", 32'(sel_a), 32'd0);
      step(1, OP_COMP_IMM, 7, 0, 8, 1, 1, 0, 0);
      check("lu_fwd2", 32'(sel_a), 32'd2);
      check("lu_done", 32'(stall), 32'd0);
      // load waits 4 cycles at stage N
      step(1, OP_LOAD, 1, 0, 3, 1, 1, 0, 0);
      nop(1);
      for (int i = 0; i < 4; i++) begin
         nop(0);
         check("lw_stall", 32'(stall), 32'hf);
      end
      nop(1);
      check("lw_release", 32'(stall), 32'h0);
      // branch flush depth 3, jump flush depth 1
      step(1, OP_NO_OP, 0, 0, 0, 0, 1, 1, 0);
      check("br_t0", 32'(clear), 32'h6);
      nop(1); check("br_t1", 32'(clear), 32'h2);
      nop(1); check("br_t2", 32'(clear), 32'h2);
      nop(1); check("br_t3", 32'(clear), 32'h0);
      step(1, OP_NO_OP, 0, 0, 0, 0, 1, 0, 1);
      check("jmp_t0", 32'(clear), 32'h2);
      nop(1); check("jmp_t1", 32'(clear), 32'h0);
      // load never answered: abort after TMO+1 stalled cycles
      step(1, OP_LOAD, 1, 0, 3, 1, 1, 0, 0);
      nop(1);
      for (int i = 0; i < TMO + 1; i++) begin
         nop(0);
         check("tmo_stall", 32'({stall, tmo}), 32'h1e);
      end
      nop(0);
      check("tmo_pulse", 32'({stall, tmo}), 32'h01);
      nop(1);
      check("tmo_once", 32'(tmo), 32'h0);
      // reset in the middle of a load wait
      step(1, OP_LOAD, 1, 0, 3, 1, 1, 0, 0);
      nop(1);
      for (int i = 0; i < 3; i++) nop(0);
      check("midwait_stall", 32'(stall), 32'hf);
      step(0, OP_NO_OP, 0, 0, 0, 0, 0, 0, 0);
      check("midwait_rst", 32'({stall, clear}), 32'h0e);
      nop(0);
      check("after_rst", 32'({stall, clear}), 32'h00);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) != 0,
              decoded_opcode'(4'($urandom_range(0, 9))),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pcu_multistage.md
Name: pcu_multistage

Overview:
- Parametrised pipeline control unit for the RI5CY-derived frontend. Tracks hazards and drives stall/clear/forward controls for a pipeline with NUM_FWD_STAGES stages downstream of ID.
- Generalises the fixed 4-stage control with:
  - per-stage stall/clear vectors
  - N-deep forwarding select
  - configurable branch/jump flush depths
  - a load-use bubble
  - x0 forwarding suppression
  - an LSU load-wait timeout with error flag

Parameters:
- ADDR_WIDTH, 5, register address width.
- NUM_FWD_STAGES, 2, tracked stages after ID (stage 1 = EX … stage N = last writeback source). Must be ≥2.
- BRANCH_FLUSH_DEPTH, 2, cycles of front-end flush after branch_taken_i. Must be ≥1.
- JUMP_FLUSH_DEPTH, 1, cycles of front-end flush after jump_taken_i. Must be ≥1.
- LOAD_TIMEOUT, 15, max LOAD_WAIT cycles before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- instr_type_i  in  decoded_opcode  type of instruction in ID
- read_addr1_i  in  ADDR_WIDTH  rs1 of ID instruction
- read_addr2_i  in  ADDR_WIDTH  rs2 of ID instruction
- write_addr_i  in  ADDR_WIDTH  rd of ID instruction
- write_en_i  in  1  ID instruction writes rd
- valid_lsu_load_i  in  1  LSU load data valid
- branch_taken_i  in  1  branch resolved taken (EX)
- jump_taken_i  in  1  jump resolved (ID)
- stall_o  out  NUM_FWD_STAGES+2  bit0 fetch, bit k = register boundary into stage k-1 (bit1 IF/ID, bit2 ID/EX, …)
- clear_o  out  NUM_FWD_STAGES+2  same indexing; bit0 always 0
- fwrd_opA_sel_o  out  $clog2(NUM_FWD_STAGES+1)  0 = register file, k = forward from stage k
- fwrd_opB_sel_o  out  $clog2(NUM_FWD_STAGES+1)  as above for rs2
- load_timeout_o  out  1  one-cycle pulse on load-wait abort

Behaviour:
- **Stage shadow registers.** Stages 1..N each hold {instr_type, write_addr, write_en}.
  - Stage k loads stage k-1 when stall_o[k+1]=0 and clear_o[k+1]=0.
  - On clear_o[k+1]=1 it loads {OP_NO_OP, 0, 0}.
  - While rst_n=0 all stages load {OP_NO_OP, 0, 0}.
- **Operand use.** Derived from the ID type:
  - OP_COMP, OP_STORE, OP_BRANCH use rs1 and rs2.
  - OP_COMP_IMM, OP_LOAD, OP_JALR use rs1 only.
  - All other types use neither.
- **Forwarding.** Select = lowest k with stage[k].write_en && write_addr == rs && rs != 0. Select = 0 if the operand is unused or no stage matches. Purely combinational.
- **Load-use.** Condition: a used operand matches stage1 (write_en, OP_LOAD, rs != 0).
  - Same cycle: stall_o[1:0]=1, clear_o[2]=1 (one bubble).
  - Forwarding selects are forced to 0 in that cycle.
- **FSM states:** RESET, WORK, FLUSH, LOAD_WAIT. Registered; outputs are combinational from the next state plus the load-use condition.
  - RESET: next=WORK when rst_n=1.
  - WORK, transition priority: (1) !rst_n → RESET; (2) stage[N].instr_type==OP_LOAD && !valid_lsu_load_i → LOAD_WAIT; (3) branch_taken_i → FLUSH, flush_cnt=BRANCH_FLUSH_DEPTH-1, flush_br=1; (4) jump_taken_i → FLUSH, flush_cnt=JUMP_FLUSH_DEPTH-1, flush_br=0; (5) else WORK.
  - FLUSH: decrement flush_cnt; when flush_cnt==0, next=WORK. A new branch/jump in FLUSH reloads the counter.
  - LOAD_WAIT: increment wait_cnt.
    - valid_lsu_load_i → FLUSH if branch_taken_i, else WORK.
    - wait_cnt==LOAD_TIMEOUT → WORK with load_timeout_o=1 for one cycle.
  - Any state with rst_n=0 → RESET; counters cleared.
- **Outputs per next state:**
  - RESET: stall=0, clear=all ones except bit0, fwd=0, load_timeout_o=0.
  - WORK: all 0, except the load-use bubble.
  - FLUSH with flush_br=1, first cycle: clear_o[2:1]=1. Remaining cycles, and every jump flush cycle: clear_o[1]=1 only.
  - LOAD_WAIT: stall_o = all ones; clear=0; fwd selects 0.
- Load-use bubble is suppressed in FLUSH and LOAD_WAIT.

Decomposition:
- In ctrl_typedefs: `pcu_state_e`, plus `pcu_stage_t` = {decoded_opcode, write_addr, write_en}.
- Sub-module `pcu_fwd_select`, parametrised by NUM_FWD_STAGES/ADDR_WIDTH:
  - inputs: rs, use flag, stage array
  - output: select
  - instantiated twice, once for opA and once for opB.

Test Plan:
- Reset held 3 cycles → clear_o=4'b1110, stall_o=0. Release → WORK, all outputs 0.
- ADD x5 followed by SUB x6,x5,x5 → fwrd_opA_sel_o=fwrd_opB_sel_o=1. One more unrelated instruction between them → selects=2. rd=x0 → selects 0.
- LW x7 followed by ADDI x8,x7,1 → one cycle stall_o[1:0]=2'b11, clear_o[2]=1. Next cycle fwrd_opA_sel_o=2 (N=2).
- LW reaches stage N, valid_lsu_load_i low 4 cycles → stall_o all ones 4 cycles. valid high → WORK.
- branch_taken_i pulse with BRANCH_FLUSH_DEPTH=3 → cycle t clear_o[2:1]=2'b11, t+1/t+2 clear_o[1]=1, t+3 WORK. jump with depth 1 → single clear_o[1].
- valid_lsu_load_i never asserted → exactly LOAD_TIMEOUT+1 stall cycles, load_timeout_o pulses once. rst_n low mid-LOAD_WAIT → RESET next cycle.
